rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//   Shares the single register-file write port between two writeback requesters.
//   Requester 0 is the ALU result path; requester 1 is the load/memory path.
//   Round-robin arbitration with valid/ready handshakes feeds a one-entry
//   registered write stage, which drives reg_write/write_reg/write_data of the 32x32 registers block.
//   Also exposes forwarding hits of the pending write against both read ports,
//   and a saturating conflict counter.
// PARAMETERS
//   DATA_W  32  register data width
//   ADDR_W  5   register address width (32 registers, r0 hardwired zero)
//   CNT_W   16  conflict counter width
// PORTS
//   clk         in   1       rising-edge clock
//   reset       in   1       asynchronous, active-high reset
//   req0_valid  in   1       ALU writeback request
//   req0_addr   in   ADDR_W  ALU destination register
//   req0_data   in   DATA_W  ALU result
//   req0_ready  out  1       ALU request accepted this cycle
//   req1_valid  in   1       load writeback request
//   req1_addr   in   ADDR_W  load destination register
//   req1_data   in   DATA_W  load data
//   req1_ready  out  1       load request accepted this cycle
//   port_busy   in   1       register-file write port unavailable this cycle
//   reg_write   out  1       write strobe to register file
//   write_reg   out  ADDR_W  write address to register file
//   write_data  out  DATA_W  write data to register file
//   read_reg1   in   ADDR_W  register-file read address 1 (for forwarding compare)
//   read_reg2   in   ADDR_W  register-file read address 2
//   fwd1_hit    out  1       pending write matches read_reg1
//   fwd2_hit    out  1       pending write matches read_reg2
//   conflict_cnt out CNT_W   cycles with both requesters valid
// BEHAVIOUR
// - Reset: out_valid=0, write_reg=0, write_data=0, last_grant=1 (so requester 0 wins first),
//   conflict_cnt=0. reg_write, readies and fwd hits are therefore 0.
// - Stage register: holds out_valid, write_reg, write_data.
//   reg_write = out_valid & ~port_busy (combinational).
// - can_accept = ~out_valid | ~port_busy (the stage is empty or drains this cycle).
// - Grant (combinational):
//   - Only one valid: that one is granted.
//   - Both valid: the requester != last_grant is granted.
//   - readyN = grantN & can_accept. At most one ready is high per cycle.
//   - A request is transferred when validN & readyN.
// - On a transfer: stage loads addr/data, and last_grant <= N.
//   - out_valid <= 1 if addr != 0.
//   - If addr == 0, out_valid <= 0: the write is accepted and dropped; r0 is never written.
// - No transfer and reg_write=1: out_valid <= 0 (write retired).
//   No transfer and port_busy=1: stage holds unchanged.
// - Latency: accept in cycle T -> reg_write high in T+1 if port_busy low in T+1.
//   Sustained throughput is 1 write/cycle.
// - Requesters hold valid/addr/data stable until ready; the block never deasserts ready
//   mid-handshake within a cycle.
// - Forwarding: fwdK_hit = out_valid & (write_reg == read_regK) & (read_regK != 0);
//   forwarding data is write_data.
// - conflict_cnt: +1 on every cycle with req0_valid & req1_valid (regardless of can_accept);
//   saturates at all-ones, no wrap.
// - Reset asserted mid-operation: the pending write is discarded immediately, with no
//   reg_write pulse. Arbitration restarts with requester 0 priority.
// TESTING
// - req0 only, addr=5, data=0xDEADBEEF in cycle T -> req0_ready=1 at T;
//   T+1: reg_write=1, write_reg=5, write_data=0xDEADBEEF.
// - Both valid for 4 cycles (addr0=3, addr1=7):
//   - grants alternate 0,1,0,1; writes to r3,r7,r3,r7 on consecutive cycles;
//   - conflict_cnt=4.
// - Stage full (addr=9) + port_busy=1 for 3 cycles, req1 valid ->
//   - req1_ready=0 and reg_write=0 while busy;
//   - r9 written in the first non-busy cycle, with req1 accepted that same cycle.
// - req1 addr=0, data=0x1234 -> req1_ready=1, no reg_write pulse follows;
//   fwd hits stay 0 with read_reg1=0.
// - Pending write r12=0xA5A5A5A5 with port_busy=1, read_reg1=12, read_reg2=13 ->
//   fwd1_hit=1, fwd2_hit=0.
// - Assert reset while out_valid=1 ->
//   - outputs clear asynchronously;
//   - after release, both valid -> requester 0 granted first;
//   - force 2^CNT_W+2 conflict cycles -> conflict_cnt holds all-ones.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single register-file write port between two
// writeback requesters (0 = ALU result, 1 = load data).
//   - Round-robin grant with valid/ready handshakes into a one-entry
//     registered write stage (out_valid, write_reg, write_data).
//   - reg_write = out_valid & ~port_busy; writes to r0 are accepted and dropped.
//   - fwd1_hit/fwd2_hit flag the pending write against the two read ports.
//   - conflict_cnt counts cycles with both requesters valid and saturates.
// Ports:
//   clk, reset                      clock, async active-high reset
//   req0_valid/addr/data, req0_ready  ALU writeback handshake
//   req1_valid/addr/data, req1_ready  load writeback handshake
//   port_busy                        write port unavailable this cycle
//   reg_write, write_reg, write_data register-file write port
//   read_reg1, read_reg2             read addresses for forwarding compare
//   fwd1_hit, fwd2_hit               pending write matches a read address
//   conflict_cnt                     saturating both-valid cycle count
module rf_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              port_busy,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic out_valid;
  logic last_grant;
  logic can_accept;
  logic grant0;
  logic grant1;
  logic xfer0;
  logic xfer1;

  // Stage can take a new write when empty or draining this cycle.
  assign can_accept = ~out_valid | ~port_busy;

  // Round-robin: on contention the requester that did not win last time wins.
  assign grant0 = req0_valid & (~req1_valid | last_grant);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant);

  assign req0_ready = grant0 & can_accept;
  assign req1_ready = grant1 & can_accept;
  assign xfer0      = req0_valid & req0_ready;
  assign xfer1      = req1_valid & req1_ready;

  assign reg_write  = out_valid & ~port_busy;

  // r0 never matches: it is hardwired zero and never pending.
  assign fwd1_hit = out_valid & (write_reg == read_reg1) & (read_reg1 != ADDR_W'(0));
  assign fwd2_hit = out_valid & (write_reg == read_reg2) & (read_reg2 != ADDR_W'(0));

  // Write stage and arbitration history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      last_grant <= 1'b1;
    end else if (xfer0) begin
      out_valid  <= (req0_addr != ADDR_W'(0));
      write_reg  <= req0_addr;
      write_data <= req0_data;
      last_grant <= 1'b0;
    end else if (xfer1) begin
      out_valid  <= (req1_addr != ADDR_W'(0));
      write_reg  <= req1_addr;
      write_data <= req1_data;
      last_grant <= 1'b1;
    end else if (reg_write) begin
      out_valid  <= 1'b0;
    end
  end

  // Saturating count of cycles where both requesters contend.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if (req0_valid && req1_valid && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req1_valid, req0_ready, req1_ready;
  logic [ADDR_W-1:0] req0_addr, req1_addr, write_reg, read_reg1, read_reg2;
  logic [DATA_W-1:0] req0_data, req1_data, write_data;
  logic              port_busy, reg_write, fwd1_hit, fwd2_hit;
  logic [CNT_W-1:0]  conflict_cnt;

  int  total = 0;
  int  bad   = 0;
  wr_t exp_q[$];

  rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .port_busy(port_busy), .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Monitor: every write strobe must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!reset && reg_write) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got r%0d=%0h expected none at %0t", write_reg, write_data, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_reg", 64'(write_reg), 64'(e.addr));
        chk("write_data", 64'(write_data), 64'(e.data));
      end
    end
  end

  initial begin
    reset = 1'b1; port_busy = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    read_reg1 = '0; read_reg2 = '0;
    #2;
    chk("rst_reg_write", 64'(reg_write), 64'd0);
    chk("rst_write_reg", 64'(write_reg), 64'd0);
    chk("rst_write_data", 64'(write_data), 64'd0);
    chk("rst_ready0", 64'(req0_ready), 64'd0);
    chk("rst_ready1", 64'(req1_ready), 64'd0);
    chk("rst_fwd", 64'({fwd1_hit, fwd2_hit}), 64'd0);
    chk("rst_cnt", 64'(conflict_cnt), 64'd0);

    // Single ALU write r5.
    step();
    reset = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    mid();
    chk("t1_ready0", 64'(req0_ready), 64'd1);
    exp_q.push_back('{addr: 5'd5, data: 32'hDEADBEEF});

    // Load write to r0: accepted, dropped.
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234;
    mid();
    chk("t4_ready1", 64'(req1_ready), 64'd1);
    step();
    req1_valid = 1'b0;
    mid();
    chk("t4_no_write", 64'(reg_write), 64'd0);
    chk("t4_fwd", 64'({fwd1_hit, fwd2_hit}), 64'd0);

    // Contention for 4 cycles: grants 0,1,0,1.
    req0_addr = 5'd3; req0_data = 32'h30;
    req1_addr = 5'd7; req1_data = 32'h70;
    for (int k = 0; k < 4; k++) begin
      step();
      req0_valid = 1'b1; req1_valid = 1'b1;
      mid();
      chk("t2_ready0", 64'(req0_ready), (k % 2 == 0) ? 64'd1 : 64'd0);
      chk("t2_ready1", 64'(req1_ready), (k % 2 == 0) ? 64'd0 : 64'd1);
      if (k % 2 == 0) exp_q.push_back('{addr: 5'd3, data: 32'h30});
      else            exp_q.push_back('{addr: 5'd7, data: 32'h70});
    end

    // Fill stage with r9, then hold port busy with a load waiting.
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
    mid();
    chk("t2_cnt", 64'(conflict_cnt), 64'd4);
    chk("t3_ready0", 64'(req0_ready), 64'd1);
    exp_q.push_back('{addr: 5'd9, data: 32'h99});
    for (int k = 0; k < 3; k++) begin
      step();
      req0_valid = 1'b0; port_busy = 1'b1;
      req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'hBB;
      mid();
      chk("t3_busy_ready1", 64'(req1_ready), 64'd0);
      chk("t3_busy_write", 64'(reg_write), 64'd0);
    end
    step();
    port_busy = 1'b0;
    mid();
    chk("t3_release_ready1", 64'(req1_ready), 64'd1);
    chk("t3_release_write", 64'(reg_write), 64'd1);
    exp_q.push_back('{addr: 5'd11, data: 32'hBB});
    step();
    req1_valid = 1'b0;
    mid();

    // Forwarding against a pending r12.
    step();
    req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'hA5A5A5A5;
    mid();
    chk("t5_ready0", 64'(req0_ready), 64'd1);
    exp_q.push_back('{addr: 5'd12, data: 32'hA5A5A5A5});
    step();
    req0_valid = 1'b0; port_busy = 1'b1;
    read_reg1 = 5'd12; read_reg2 = 5'd13;
    mid();
    chk("t5_fwd1", 64'(fwd1_hit), 64'd1);
    chk("t5_fwd2", 64'(fwd2_hit), 64'd0);
    chk("t5_fwd_data", 64'(write_data), 64'hA5A5A5A5);
    step();
    port_busy = 1'b0; read_reg1 = '0; read_reg2 = '0;
    mid();

    // Reset with a pending write r20 held by a busy port.
    step();
    port_busy = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd20; req0_data = 32'h2020;
    mid();
    chk("t6_ready0", 64'(req0_ready), 64'd1);
    step();
    req0_valid = 1'b0; read_reg1 = 5'd20;
    mid();
    chk("t6_pending_fwd", 64'(fwd1_hit), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_write_reg", 64'(write_reg), 64'd0);
    chk("t6_rst_write_data", 64'(write_data), 64'd0);
    chk("t6_rst_fwd", 64'(fwd1_hit), 64'd0);
    port_busy = 1'b0;
    #1;
    chk("t6_rst_reg_write", 64'(reg_write), 64'd0);
    step();
    reset = 1'b0; read_reg1 = '0;
    req0_addr = 5'd1; req0_data = 32'h11;
    req1_addr = 5'd2; req1_data = 32'h22;

    // Both valid for 2^CNT_W+2 cycles: req0 first, then alternate; counter saturates.
    for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
      if (i != 0) step();
      req0_valid = 1'b1; req1_valid = 1'b1;
      mid();
      chk("t6_ready0", 64'(req0_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
      chk("t6_ready1", 64'(req1_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
      if (i % 2 == 0) exp_q.push_back('{addr: 5'd1, data: 32'h11});
      else            exp_q.push_back('{addr: 5'd2, data: 32'h22});
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    mid();
    chk("t6_cnt_sat", 64'(conflict_cnt), 64'({CNT_W{1'b1}}));
    step();
    step();
    mid();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
